// File: rtl/stream_packetizer.sv
// stream_packetizer: groups a valid/ready beat stream into PKT_LEN-beat packets behind one registered output stage.
// Define STREAM_PKT_CHECKSUM_EN to append a modular-sum trailer beat (last=1) after each packet's payload.
module stream_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  dataInValid,
    output logic                  dataInReady,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataOutValid,
    output logic                  dataOutLast,
    input  logic                  dataOutReady,
    output logic [15:0]           pktCount
);
    localparam int CW = $clog2(PKT_LEN + 1);

    logic [CW-1:0] r_beat_cnt;
    logic          w_load_ok;
    logic          w_accept;
    logic          w_pkt_end;
    logic          w_in_ready;

    assign w_load_ok   = ~dataOutValid | dataOutReady;
    assign w_pkt_end   = r_beat_cnt == CW'(PKT_LEN - 1);
    assign w_accept    = dataInValid & w_in_ready;
    assign dataInReady = w_in_ready;

`ifdef STREAM_PKT_CHECKSUM_EN
    typedef enum logic {PAYLOAD, TRAILER} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_sum;

    always_ff @(posedge clk) begin
        r_state <= resetn ? PAYLOAD : w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == PAYLOAD && w_accept && w_pkt_end)
            w_next_state = TRAILER;
        else if (r_state == TRAILER && w_load_ok)
            w_next_state = PAYLOAD;
    end

    always_comb begin
        w_in_ready = ~resetn & (r_state == PAYLOAD) & w_load_ok;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            dataOut      <= '0;
            dataOutValid <= 1'b0;
            dataOutLast  <= 1'b0;
            r_beat_cnt   <= '0;
            r_sum        <= '0;
        end else if (w_accept) begin
            dataOut      <= dataIn;
            dataOutValid <= 1'b1;
            dataOutLast  <= 1'b0;
            r_sum        <= r_sum + dataIn;
            r_beat_cnt   <= w_pkt_end ? '0 : r_beat_cnt + 1'b1;
        end else if (r_state == TRAILER && w_load_ok) begin
            dataOut      <= r_sum;
            dataOutValid <= 1'b1;
            dataOutLast  <= 1'b1;
            r_sum        <= '0;
        end else if (w_load_ok) begin
            dataOutValid <= 1'b0;
            dataOutLast  <= 1'b0;
        end
    end
`else
    always_comb begin
        w_in_ready = ~resetn & w_load_ok;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            dataOut      <= '0;
            dataOutValid <= 1'b0;
            dataOutLast  <= 1'b0;
            r_beat_cnt   <= '0;
        end else if (w_accept) begin
            dataOut      <= dataIn;
            dataOutValid <= 1'b1;
            dataOutLast  <= w_pkt_end;
            r_beat_cnt   <= w_pkt_end ? '0 : r_beat_cnt + 1'b1;
        end else if (w_load_ok) begin
            dataOutValid <= 1'b0;
            dataOutLast  <= 1'b0;
        end
    end
`endif

    // A packet counts as delivered when its last beat leaves the output register.
    always_ff @(posedge clk) begin
        if (resetn)
            pktCount <= '0;
        else if (dataOutValid & dataOutReady & dataOutLast)
            pktCount <= pktCount + 16'd1;
    end
endmodule

// File: tb/tb_stream_packetizer.sv
// tb_stream_packetizer: directed stimulus pushes hand-computed beats into a queue; a negedge monitor pops and compares.
// Expectations follow STREAM_PKT_CHECKSUM_EN so the same bench covers both builds.
module tb_stream_packetizer;
`ifdef STREAM_PKT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] dataIn = '0;
    logic        dataInValid = 1'b0;
    logic        dataInReady;
    logic [31:0] dataOut;
    logic        dataOutValid;
    logic        dataOutLast;
    logic        dataOutReady = 1'b1;
    logic [15:0] pktCount;

    logic [32:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    stream_packetizer #(.DATA_WIDTH(32), .PKT_LEN(4)) dut (
        .clk(clk), .resetn(resetn),
        .dataIn(dataIn), .dataInValid(dataInValid), .dataInReady(dataInReady),
        .dataOut(dataOut), .dataOutValid(dataOutValid), .dataOutLast(dataOutLast),
        .dataOutReady(dataOutReady), .pktCount(pktCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a beat is transferred at the next posedge when valid & ready are seen here.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!resetn && dataOutValid && dataOutReady) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got last=%b data=%h expected no beat", dataOutLast, dataOut);
            end else begin
                e = exp_q.pop_front();
                check("out_beat", {dataOutLast, dataOut}, e);
            end
        end
    end

    task automatic send(input logic [31:0] d);
        int  n = 0;
        logic ok = 1'b0;
        dataIn = d;
        dataInValid = 1'b1;
        do begin
            @(negedge clk);
            ok = dataInReady;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept of %h expected accept within 50 cycles", d);
        end
        dataInValid = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] d3, input logic [31:0] tr);
        logic [31:0] d[4];
        logic        l;
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            l = (i == 3) && !CK;
            exp_q.push_back({l, d[i]});
        end
        if (CK) exp_q.push_back({1'b1, tr});
        for (int i = 0; i < 4; i++) send(d[i]);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", 33'(exp_q.size()), 33'd0);
    endtask

    initial begin
        int c0;
        // Reset held with valid input: nothing accepted or emitted.
        dataInValid = 1'b1;
        dataIn = 32'h55;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_valid", 33'(dataOutValid), 33'd0);
            check("rst_pkt", 33'(pktCount), 33'd0);
            check("rst_ready", 33'(dataInReady), 33'd0);
        end
        resetn = 1'b0;
        dataInValid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 33'(dataInReady), 33'd1);
        check("post_rst_valid", 33'(dataOutValid), 33'd0);
        @(posedge clk);
        #1;

        // Streaming 1..8 at full throughput; checksum build pays one bubble between packets.
        c0 = cyc;
        send_pkt(32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A);
        send_pkt(32'd5, 32'd6, 32'd7, 32'd8, 32'h0000001A);
        check("stream_cycles", 33'(cyc - c0), CK ? 33'd9 : 33'd8);
        drain();
        check("stream_pkt", 33'(pktCount), 33'd2);

        // Backpressure mid-packet: output frozen on beat 10, input blocked.
        exp_q.push_back({1'b0, 32'd9});
        exp_q.push_back({1'b0, 32'd10});
        exp_q.push_back({1'b0, 32'd11});
        exp_q.push_back({!CK, 32'd12});
        if (CK) exp_q.push_back({1'b1, 32'h0000002A});
        send(32'd9);
        send(32'd10);
        dataOutReady = 1'b0;
        dataIn = 32'd11;
        dataInValid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_data", 33'(dataOut), 33'd10);
            check("bp_last", 33'(dataOutLast), 33'd0);
            check("bp_valid", 33'(dataOutValid), 33'd1);
            check("bp_ready", 33'(dataInReady), 33'd0);
            @(posedge clk);
            #1;
        end
        dataOutReady = 1'b1;
        send(32'd11);
        send(32'd12);
        drain();
        check("bp_pkt", 33'(pktCount), 33'd3);

        // Sum wraps modulo 2^32.
        send_pkt(32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 32'h00000001);
        drain();
        check("ovf_pkt", 33'(pktCount), 33'd4);

        // Reset after two beats: beat 1 already left, beat 2 is discarded.
        exp_q.push_back({1'b0, 32'd1});
        send(32'd1);
        send(32'd2);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_pkt", 33'(pktCount), 33'd0);
        check("mid_rst_valid", 33'(dataOutValid), 33'd0);
        resetn = 1'b0;
        send_pkt(32'd5, 32'd6, 32'd7, 32'd8, 32'h0000001A);
        drain();
        check("mid_rst_final_pkt", 33'(pktCount), 33'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1);
    end
endmodule
